// File: rtl/wptr_full_lvl.sv
// Write-side pointer and flag controller for an asynchronous FIFO (wclk domain).
// Produces the binary RAM write address, the Gray write pointer handed to the
// read-domain synchroniser, and registered full / almost_full / fill-level flags.
// The overflow flag reports writes attempted while full.
//
// Optional feature macro: WPTR_OVF_STICKY_EN
//   defined   -> overflow is sticky until rst or ovf_clr (a set on the same
//                edge as a clear wins)
//   undefined -> overflow is a one-cycle pulse and ovf_clr is ignored
module wptr_full_lvl #(
  parameter int ADDR_WIDTH = 3,
  parameter int AF_THRESH  = 6
) (
  input  logic                  wclk,
  input  logic                  rst,
  input  logic                  winc,
  input  logic [ADDR_WIDTH:0]   rptr_sync,
  input  logic                  ovf_clr,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wlevel,
  output logic                  overflow
);

  // Threshold in pointer width; 2^ADDR_WIDTH still fits in ADDR_WIDTH+1 bits.
  localparam logic [ADDR_WIDTH:0] AF_TH = AF_THRESH[ADDR_WIDTH:0];

  function automatic logic [ADDR_WIDTH:0] bin2gray(input logic [ADDR_WIDTH:0] b);
    return (b >> 1) ^ b;
  endfunction

  // Prefix XOR from the MSB down.
  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [ADDR_WIDTH:0] wbin;
  logic                wen;
  logic [ADDR_WIDTH:0] wbin_next;
  logic [ADDR_WIDTH:0] wgray_next;
  logic [ADDR_WIDTH:0] rbin_sync;
  logic [ADDR_WIDTH:0] level_next;
  logic [ADDR_WIDTH:0] full_cmp;

  assign wen        = winc & ~full;
  assign wbin_next  = wbin + {{ADDR_WIDTH{1'b0}}, wen};
  assign wgray_next = bin2gray(wbin_next);
  assign rbin_sync  = gray2bin(rptr_sync);
  // Modulo subtract absorbs wrap of either pointer.
  assign level_next = wbin_next - rbin_sync;
  // Full when the write pointer is one lap ahead: top two Gray bits inverted.
  assign full_cmp   = {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]};
  assign waddr      = wbin[ADDR_WIDTH-1:0];

  // Pointer, full, level and almost_full registers; level and almost_full share level_next.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      wbin        <= '0;
      wptr        <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
    end else begin
      wbin        <= wbin_next;
      wptr        <= wgray_next;
      full        <= (wgray_next == full_cmp);
      almost_full <= (level_next >= AF_TH);
      wlevel      <= level_next;
    end
  end

`ifdef WPTR_OVF_STICKY_EN
  // Sticky overflow: set on a rejected write, cleared by ovf_clr; set wins.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (winc & full) begin
      overflow <= 1'b1;
    end else if (ovf_clr) begin
      overflow <= 1'b0;
    end
  end
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;

  // Pulsed overflow: high for the cycle after a rejected write.
  always_ff @(posedge wclk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else begin
      overflow <= winc & full;
    end
  end
`endif

endmodule

// File: doc/wptr_full_lvl.md
Name: wptr_full_lvl

Overview:
Write-side pointer/flag controller for the async FIFO, next generation of the write-pointer/full block.
- Generates the binary write address, the Gray write pointer for the read-domain synchroniser, and a registered full flag.
- Adds, over the previous generation: a registered fill level, a threshold-based almost_full flag, and overflow error reporting.
- Sits in the wclk domain between the write client and the dual-port RAM / pointer synchroniser.

Parameters:
ADDR_WIDTH, 3, RAM address bits; depth = 2^ADDR_WIDTH; legal range >= 2.
AF_THRESH, 6, almost_full asserts when level >= AF_THRESH; legal range 1..2^ADDR_WIDTH.

Ports:
wclk  input  1  write clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
winc  input  1  write request; accepted only when full=0.
rptr_sync  input  ADDR_WIDTH+1  read pointer (Gray), already synchronised into wclk.
ovf_clr  input  1  clears the sticky overflow flag; used only with the optional feature.
waddr  output  ADDR_WIDTH  RAM write address = wbin[ADDR_WIDTH-1:0].
wptr  output  ADDR_WIDTH+1  registered Gray write pointer.
full  output  1  FIFO full, registered.
almost_full  output  1  level >= AF_THRESH, registered.
wlevel  output  ADDR_WIDTH+1  occupancy seen from the write side, 0..2^ADDR_WIDTH, registered.
overflow  output  1  write attempted while full.

Behaviour:
- Reset (rst=1, asynchronous): wbin=0, wptr=0, full=0, almost_full=0, wlevel=0, overflow=0. All outputs are forced immediately, independent of wclk.
- Write accept: wen = winc & ~full.
  - wbin_next = wbin + wen, modulo 2^(ADDR_WIDTH+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Every rising wclk edge (rst=0) updates:
  - wbin <= wbin_next
  - wptr <= wgray_next
- waddr is combinational from the registered wbin. It addresses the RAM location written in the cycle winc is accepted.
- Full, every edge: full <= (wgray_next == {~rptr_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_sync[ADDR_WIDTH-2:0]}).
  - full asserts on the same edge that accepts the last free slot.
  - full deasserts on the first edge after rptr_sync advances.
- Level:
  - rbin_sync = Gray-to-binary of rptr_sync (prefix XOR, MSB down).
  - wlevel <= (wbin_next - rbin_sync), ADDR_WIDTH+1-bit modulo arithmetic.
  - Wrap of either pointer through 2^(ADDR_WIDTH+1) → 0 is handled by the modulo subtract.
- almost_full <= (wbin_next - rbin_sync) >= AF_THRESH. It uses the same next-state value as wlevel, so the two flags are always mutually consistent in any cycle.
- Overflow (base behaviour): overflow <= winc & full. It is a one-cycle pulse registered at the edge where the write was rejected.
  - A rejected write never changes wbin, wptr or waddr.
- Simultaneous winc and rptr_sync change in the same cycle: full, level and almost_full are computed from the current cycle's winc and rptr_sync together; no priority between them.
- rptr_sync is assumed Gray-coherent, i.e. at most one bit changes per wclk as delivered by the 2-FF synchroniser. A non-Gray step yields a transiently wrong level but never corrupts wbin.

Optional Feature:
Macro WPTR_OVF_STICKY_EN.
- Defined: overflow is sticky. It sets on the edge where winc & full, and holds until rst or an edge with ovf_clr=1. If set and clear occur on the same edge, set wins.
- Undefined: overflow is the one-cycle pulse described above, and ovf_clr is ignored.

Test Plan:
All scenarios use ADDR_WIDTH=3 (depth 8) and AF_THRESH=6.
1. Fill: rptr_sync=4'b0000, winc=1 for 8 cycles → after the 6th edge almost_full=1, wlevel=6; after the 8th edge full=1, wlevel=8, wptr=4'b1100, waddr=0.
2. Overflow: from full, winc=1 for 1 cycle → overflow=1 for exactly 1 cycle (2+ cycles held with WPTR_OVF_STICKY_EN until ovf_clr), wptr stays 4'b1100, wlevel stays 8.
3. Drain release: from full, rptr_sync=4'b0001 (gray 1), winc=0 → next edge full=0, wlevel=7, almost_full=1. Then rptr_sync=4'b0011 (gray 2) → wlevel=6, and rptr_sync=4'b0010 (gray 3) → wlevel=5, almost_full=0.
4. Simultaneous: wlevel=7, winc=1 while rptr_sync steps by one → wlevel stays 7, full=0, waddr increments.
5. Wrap: 16 accepted writes with rptr_sync tracking 2 behind → wbin wraps to 0, wptr=4'b0000 after the 16th edge, wlevel=2 throughout steady state, full never asserts.
6. Async reset mid-burst: rst=1 between edges at wlevel=5 → all outputs 0 immediately without a wclk edge. After release, the first write gives waddr=0 and wptr=4'b0001.
